// File: rtl/wb_arbiter_rr.sv
// Wishbone N-master to 1-slave round-robin arbiter with registered grant,
// zero-bubble handover and an optional stall watchdog.

module wb_arb_lane (
    input  logic sel,
    input  logic s_ack,
    input  logic s_err,
    input  logic s_rty,
    output logic ack,
    output logic err,
    output logic rty
);
    assign ack = sel & s_ack;
    assign err = sel & s_err;
    assign rty = sel & s_rty;
endmodule

module wb_arbiter_rr #(
    parameter int MASTERS    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [MASTERS-1:0][ADDR_WIDTH-1:0]    m_adr_i,
    input  logic [MASTERS-1:0][DATA_WIDTH-1:0]    m_dat_i,
    input  logic [MASTERS-1:0]                    m_cyc_i,
    input  logic [MASTERS-1:0]                    m_stb_i,
    input  logic [MASTERS-1:0][(DATA_WIDTH>>3)-1:0] m_sel_i,
    input  logic [MASTERS-1:0]                    m_we_i,
    input  logic [MASTERS-1:0][2:0]               m_cti_i,
    input  logic [MASTERS-1:0][1:0]               m_bte_i,
    output logic [MASTERS-1:0][DATA_WIDTH-1:0]    m_dat_o,
    output logic [MASTERS-1:0]                    m_ack_o,
    output logic [MASTERS-1:0]                    m_err_o,
    output logic [MASTERS-1:0]                    m_rty_o,
    output logic [ADDR_WIDTH-1:0]                 s_adr_o,
    output logic [DATA_WIDTH-1:0]                 s_dat_o,
    output logic [(DATA_WIDTH>>3)-1:0]            s_sel_o,
    output logic                                  s_we_o,
    output logic [2:0]                            s_cti_o,
    output logic [1:0]                            s_bte_o,
    output logic                                  s_cyc_o,
    output logic                                  s_stb_o,
    input  logic [DATA_WIDTH-1:0]                 s_dat_i,
    input  logic                                  s_ack_i,
    input  logic                                  s_err_i,
    input  logic                                  s_rty_i,
    output logic                                  grant_valid_o,
    output logic [((MASTERS > 1) ? $clog2(MASTERS) : 1)-1:0] grant_o,
    output logic                                  timeout_o
);
    localparam int SEL_WIDTH = DATA_WIDTH >> 3;
    localparam int GRANT_W   = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] adr;
        logic [DATA_WIDTH-1:0] dat;
        logic [SEL_WIDTH-1:0]  sel;
        logic                  we;
        logic [2:0]            cti;
        logic [1:0]            bte;
    } wb_req_t;

    state_t                   state_q, state_d;
    logic [GRANT_W-1:0]       grant_q, grant_d;
    logic [GRANT_W-1:0]       last_q, last_d;
    logic [GRANT_W-1:0]       pick;
    logic                     found;
    int                       idx;
    logic                     owned, arb_run;
    logic                     cyc_sel, stb_sel;
    logic                     wd_fire;
    wb_req_t [MASTERS-1:0]    req;
    wb_req_t                  s_req;

    assign owned   = (state_q == OWNED);
    assign cyc_sel = owned & m_cyc_i[grant_q];
    assign stb_sel = owned & m_stb_i[grant_q];
    // Arbitration also runs on the owner's release edge, which gives zero-bubble handover.
    assign arb_run = ~owned | ~m_cyc_i[grant_q];

    // Search starts just past the last winner, so the releasing master comes last.
    always_comb begin
        found = 1'b0;
        pick  = grant_q;
        idx   = 0;
        for (int i = 1; i <= MASTERS; i++) begin
            idx = (int'(last_q) + i) % MASTERS;
            if (!found && m_cyc_i[GRANT_W'(idx)]) begin
                found = 1'b1;
                pick  = GRANT_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GRANT_W'(MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (arb_run) begin
            if (found) begin
                state_d = OWNED;
                grant_d = pick;
                last_d  = pick;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        s_req   = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (owned) begin
            s_req   = req[grant_q];
            s_cyc_o = cyc_sel;
            s_stb_o = stb_sel & ~wd_fire;
        end
    end

    assign s_adr_o       = s_req.adr;
    assign s_dat_o       = s_req.dat;
    assign s_sel_o       = s_req.sel;
    assign s_we_o        = s_req.we;
    assign s_cti_o       = s_req.cti;
    assign s_bte_o       = s_req.bte;
    assign grant_valid_o = owned;
    assign grant_o       = grant_q;

    for (genvar g = 0; g < MASTERS; g++) begin : g_lane
        assign req[g] = '{adr: m_adr_i[g], dat: m_dat_i[g], sel: m_sel_i[g],
                          we: m_we_i[g], cti: m_cti_i[g], bte: m_bte_i[g]};
        assign m_dat_o[g] = s_dat_i;

        wb_arb_lane u_lane (
            .sel   (owned && (grant_q == GRANT_W'(g))),
            .s_ack (s_ack_i),
            .s_err (s_err_i | wd_fire),
            .s_rty (s_rty_i),
            .ack   (m_ack_o[g]),
            .err   (m_err_o[g]),
            .rty   (m_rty_o[g])
        );
    end

    if (TIMEOUT > 0) begin : g_wdog
        localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
        logic [WD_W-1:0] wdog;
        logic            resp, stalled, tmo_q;

        // Raw strobe is used here so the stall term does not loop through wd_fire.
        assign resp    = s_ack_i | s_err_i | s_rty_i;
        assign stalled = cyc_sel & stb_sel & ~resp;
        assign wd_fire = stalled & (wdog == WD_W'(TIMEOUT - 1));

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wdog  <= '0;
                tmo_q <= 1'b0;
            end else begin
                tmo_q <= wd_fire;
                if (stalled)
                    wdog <= wd_fire ? '0 : wdog + 1'b1;
                else if (!cyc_sel || resp)
                    wdog <= '0;
            end
        end
        assign timeout_o = tmo_q;
    end else begin : g_no_wdog
        assign wd_fire   = 1'b0;
        assign timeout_o = 1'b0;
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: 3 masters, 8-cycle watchdog.

module tb_wb_arbiter_rr;
    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [2:0][31:0]  m_adr_i, m_dat_i;
    logic [2:0]        m_cyc_i, m_stb_i, m_we_i;
    logic [2:0][3:0]   m_sel_i;
    logic [2:0][2:0]   m_cti_i;
    logic [2:0][1:0]   m_bte_i;
    logic [2:0][31:0]  m_dat_o;
    logic [2:0]        m_ack_o, m_err_o, m_rty_o;
    logic [31:0]       s_adr_o, s_dat_o;
    logic [3:0]        s_sel_o;
    logic              s_we_o;
    logic [2:0]        s_cti_o;
    logic [1:0]        s_bte_o;
    logic              s_cyc_o, s_stb_o;
    logic [31:0]       s_dat_i;
    logic              s_ack_i, s_err_i, s_rty_i;
    logic              grant_valid_o;
    logic [1:0]        grant_o;
    logic              timeout_o;

    int vec  = 0;
    int errs = 0;

    wb_arbiter_rr #(.MASTERS(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_valid_o(grant_valid_o), .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        vec++; if (grant_valid_o !== 1'b0) begin errs++; $display("FAIL rst_gv: got %0h want 0", grant_valid_o); end
        vec++; if (grant_o !== 2'd0) begin errs++; $display("FAIL rst_grant: got %0h want 0", grant_o); end
        vec++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin errs++; $display("FAIL rst_cyc_stb: got %0h want 0", {s_cyc_o, s_stb_o}); end
        vec++; if ({m_ack_o, m_err_o, m_rty_o} !== 9'd0) begin errs++; $display("FAIL rst_resp: got %0h want 0", {m_ack_o, m_err_o, m_rty_o}); end
        vec++; if (timeout_o !== 1'b0) begin errs++; $display("FAIL rst_tmo: got %0h want 0", timeout_o); end
        rst_i = 1'b0;
        tick;
        vec++; if (s_adr_o !== 32'd0) begin errs++; $display("FAIL idle_adr_zero: got %0h want 0", s_adr_o); end
        vec++; if (grant_valid_o !== 1'b0) begin errs++; $display("FAIL idle_gv: got %0h want 0", grant_valid_o); end
    endtask

    task automatic test_round_robin;
        int eg;
        m_cyc_i = 3'b111; m_stb_i = 3'b111;
        tick;
        for (int k = 0; k < 4; k++) begin
            eg = k % 3;
            #1;
            vec++; if (grant_o !== 2'(eg)) begin errs++; $display("FAIL rr_grant%0d: got %0d want %0d", k, grant_o, eg); end
            vec++; if ({grant_valid_o, s_cyc_o} !== 2'b11) begin errs++; $display("FAIL rr_owned%0d: got %0h want 3", k, {grant_valid_o, s_cyc_o}); end
            vec++; if (s_adr_o !== (32'hA000_0000 | 32'(eg))) begin errs++; $display("FAIL rr_adr%0d: got %0h want %0h", k, s_adr_o, 32'hA000_0000 | 32'(eg)); end
            s_ack_i = 1'b1;
            #1;
            vec++; if (m_ack_o !== 3'(1 << eg)) begin errs++; $display("FAIL rr_ack%0d: got %0b want %0b", k, m_ack_o, 3'(1 << eg)); end
            tick;
            s_ack_i = 1'b0; m_cyc_i[eg] = 1'b0; m_stb_i[eg] = 1'b0;
            #1;
            vec++; if (s_cyc_o !== 1'b0) begin errs++; $display("FAIL rr_release%0d: got %0h want 0", k, s_cyc_o); end
            tick;
            m_cyc_i[eg] = 1'b1; m_stb_i[eg] = 1'b1;
        end
        m_cyc_i = '0; m_stb_i = '0;
        tick;
        vec++; if ({grant_valid_o, s_cyc_o} !== 2'b00) begin errs++; $display("FAIL rr_idle: got %0h want 0", {grant_valid_o, s_cyc_o}); end
    endtask

    task automatic test_single;
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_we_i[1] = 1'b0; m_sel_i[1] = 4'h3;
        #1;
        vec++; if (s_cyc_o !== 1'b0) begin errs++; $display("FAIL single_latency: got %0h want 0", s_cyc_o); end
        tick;
        vec++; if ({s_cyc_o, grant_o} !== 3'b101) begin errs++; $display("FAIL single_grant: got %0h want 5", {s_cyc_o, grant_o}); end
        vec++; if ({s_we_o, s_sel_o} !== 5'h03) begin errs++; $display("FAIL single_we_sel: got %0h want 3", {s_we_o, s_sel_o}); end
        tick;
        vec++; if (m_ack_o !== 3'b000) begin errs++; $display("FAIL single_noack: got %0b want 000", m_ack_o); end
        tick;
        s_dat_i = 32'hCAFE_F00D; s_ack_i = 1'b1;
        #1;
        vec++; if (m_ack_o !== 3'b010) begin errs++; $display("FAIL single_ack: got %0b want 010", m_ack_o); end
        vec++; if (m_dat_o !== {3{32'hCAFE_F00D}}) begin errs++; $display("FAIL single_dat: got %0h want bcast cafef00d", m_dat_o); end
        vec++; if (m_err_o !== 3'b000) begin errs++; $display("FAIL single_err: got %0b want 000", m_err_o); end
        tick;
        s_ack_i = 1'b0; m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0; m_we_i[1] = 1'b1; m_sel_i[1] = 4'hF;
        tick;
        vec++; if (grant_valid_o !== 1'b0) begin errs++; $display("FAIL single_idle: got %0h want 0", grant_valid_o); end
    endtask

    task automatic test_burst;
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_cti_i[0] = 3'b010;
        tick;
        m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1; s_ack_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) m_cti_i[0] = 3'b111;
            #1;
            vec++; if (grant_o !== 2'd0) begin errs++; $display("FAIL burst_grant%0d: got %0d want 0", b, grant_o); end
            vec++; if (m_ack_o !== 3'b001) begin errs++; $display("FAIL burst_ack%0d: got %0b want 001", b, m_ack_o); end
            vec++; if (s_cti_o !== ((b == 3) ? 3'b111 : 3'b010)) begin errs++; $display("FAIL burst_cti%0d: got %0b", b, s_cti_o); end
            tick;
        end
        s_ack_i = 1'b0; m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0; m_cti_i[0] = 3'b000;
        #1;
        vec++; if ({s_cyc_o, grant_o} !== 3'b000) begin errs++; $display("FAIL burst_release: got %0h want 0", {s_cyc_o, grant_o}); end
        tick;
        vec++; if ({s_cyc_o, grant_o} !== 3'b110) begin errs++; $display("FAIL burst_handover: got %0h want 6", {s_cyc_o, grant_o}); end
        vec++; if (s_adr_o !== 32'hA000_0002) begin errs++; $display("FAIL burst_adr2: got %0h want a0000002", s_adr_o); end
        s_ack_i = 1'b1;
        tick;
        s_ack_i = 1'b0; m_cyc_i[2] = 1'b0; m_stb_i[2] = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1;
        tick;
        for (int c = 1; c < 8; c++) begin
            vec++; if ({m_err_o, s_stb_o, timeout_o} !== 5'b00010) begin errs++; $display("FAIL wd_stall%0d: got %0b want 00010", c, {m_err_o, s_stb_o, timeout_o}); end
            tick;
        end
        vec++; if (m_err_o !== 3'b001) begin errs++; $display("FAIL wd_err: got %0b want 001", m_err_o); end
        vec++; if (s_stb_o !== 1'b0) begin errs++; $display("FAIL wd_stb_kill: got %0h want 0", s_stb_o); end
        tick;
        vec++; if (timeout_o !== 1'b1) begin errs++; $display("FAIL wd_pulse: got %0h want 1", timeout_o); end
        vec++; if ({m_err_o, s_stb_o} !== 4'b0001) begin errs++; $display("FAIL wd_restart: got %0b want 0001", {m_err_o, s_stb_o}); end
        tick;
        vec++; if (timeout_o !== 1'b0) begin errs++; $display("FAIL wd_pulse_end: got %0h want 0", timeout_o); end
        m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
        tick;
    endtask

    task automatic test_ack_err;
        m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1;
        tick;
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1;
        s_ack_i = 1'b1; s_err_i = 1'b1;
        #1;
        vec++; if (m_ack_o !== 3'b100) begin errs++; $display("FAIL ae_ack: got %0b want 100", m_ack_o); end
        vec++; if (m_err_o !== 3'b100) begin errs++; $display("FAIL ae_err: got %0b want 100", m_err_o); end
        vec++; if (m_rty_o !== 3'b000) begin errs++; $display("FAIL ae_rty: got %0b want 000", m_rty_o); end
        tick;
        s_ack_i = 1'b0; s_err_i = 1'b0; m_cyc_i[2] = 1'b0; m_stb_i[2] = 1'b0;
        tick;
        vec++; if (grant_o !== 2'd1) begin errs++; $display("FAIL ae_next_grant: got %0d want 1", grant_o); end
        m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1; m_cti_i[2] = 3'b010;
        tick;
        m_cyc_i = 3'b111; m_stb_i = 3'b111; s_ack_i = 1'b1;
        #1;
        vec++; if ({s_cyc_o, grant_o} !== 3'b110) begin errs++; $display("FAIL rm_pre: got %0h want 6", {s_cyc_o, grant_o}); end
        rst_i = 1'b1;
        #1;
        vec++; if ({s_cyc_o, s_stb_o, grant_valid_o} !== 3'b000) begin errs++; $display("FAIL rm_drop: got %0b want 000", {s_cyc_o, s_stb_o, grant_valid_o}); end
        vec++; if (m_ack_o !== 3'b000) begin errs++; $display("FAIL rm_ack: got %0b want 000", m_ack_o); end
        #1;
        rst_i = 1'b0; s_ack_i = 1'b0; m_cti_i[2] = 3'b000;
        tick;
        vec++; if ({grant_valid_o, grant_o} !== 3'b100) begin errs++; $display("FAIL rm_prio0: got %0h want 4", {grant_valid_o, grant_o}); end
        m_cyc_i = '0; m_stb_i = '0;
        tick;
    endtask

    initial begin
        rst_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_adr_i[k] = 32'hA000_0000 | 32'(k);
            m_dat_i[k] = 32'hD000_0000 | 32'(k);
            m_sel_i[k] = 4'hF;
        end
        m_cyc_i = '0; m_stb_i = '0; m_we_i = 3'b111; m_cti_i = '0; m_bte_i = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        test_reset;
        test_round_robin;
        test_single;
        test_burst;
        test_timeout;
        test_ack_err;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
